grad_img_sender: RTL and testbench

GRAD_IMG_SENDER -- requirements
Module: grad_img_sender

---
 rtl/grad_img_sender.sv | 124 ++++++++++++
 tb/tb_grad_img_sender.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/grad_img_sender.sv
// grad_img_sender: streams the X then Y gradient BRAM images over an 8N1 UART, LSB first.
// Define GRAD_SYNC_HEADER_EN to prefix each plane with the sync bytes 0xA5, 0x5A.
module grad_img_sender #(
    parameter int WIDTH           = 64,
    parameter int HEIGHT          = 64,
    parameter int BIT_DEPTH       = 8,
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   x_read_addr,
    input  logic [BIT_DEPTH-1:0]              x_pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   y_read_addr,
    input  logic [BIT_DEPTH-1:0]              y_pixel_in,
    output logic                              tx,
    output logic                              busy,
    output logic                              done
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = $clog2(N);
`ifdef GRAD_SYNC_HEADER_EN
    localparam int TOTAL = 2 * N + 4;
`else
    localparam int TOTAL = 2 * N;
`endif
    localparam int FW = $clog2(TOTAL);
    localparam int BW = $clog2(CLOCKS_PER_BAUD);

    typedef enum logic [1:0] {IDLE, PRIME, SEND, FINISH} state_t;

    state_t               r_state, w_next_state;
    logic [AW-1:0]        r_addr;
    logic                 r_plane;
    logic [BW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [9:0]           r_shift;
    logic [FW-1:0]        r_frames;
    logic                 w_bit_end, w_frame_end, w_load, w_is_pix;
    logic [BIT_DEPTH-1:0] w_pixel, w_byte;
`ifdef GRAD_SYNC_HEADER_EN
    logic [1:0]           r_hdr;
    assign w_is_pix = r_hdr == 2'd2;
    assign w_byte   = (r_hdr == 2'd0) ? 8'hA5 : (r_hdr == 2'd1) ? 8'h5A : w_pixel;
`else
    assign w_is_pix = 1'b1;
    assign w_byte   = w_pixel;
`endif

    assign w_pixel     = r_plane ? y_pixel_in : x_pixel_in;
    assign x_read_addr = r_plane ? '0 : r_addr;
    assign y_read_addr = r_plane ? r_addr : '0;
    assign tx          = (r_state == SEND) ? r_shift[0] : 1'b1;
    assign busy        = (r_state == PRIME) || (r_state == SEND);
    assign done        = r_state == FINISH;
    assign w_bit_end   = r_baud == BW'(CLOCKS_PER_BAUD - 1);
    assign w_frame_end = w_bit_end && (r_bit == 4'd9);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // PRIME waits out the 2-cycle BRAM latency for address 0 before loading byte 0
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE:   w_next_state = start_in ? PRIME : IDLE;
            PRIME:  begin
                w_load       = r_baud == BW'(2);
                w_next_state = w_load ? SEND : PRIME;
            end
            SEND:   begin
                w_load       = w_frame_end && (r_frames != FW'(TOTAL - 1));
                w_next_state = (w_frame_end && !w_load) ? FINISH : SEND;
            end
            FINISH: w_next_state = IDLE;
        endcase
    end

    // Address advances right after each pixel load, so the next pixel is ready long before the frame ends
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_addr   <= '0;
            r_plane  <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_frames <= '0;
`ifdef GRAD_SYNC_HEADER_EN
            r_hdr    <= '0;
`endif
        end else if (r_state == IDLE) begin
            r_addr   <= '0;
            r_plane  <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_frames <= '0;
`ifdef GRAD_SYNC_HEADER_EN
            r_hdr    <= '0;
`endif
        end else begin
            r_baud <= (w_load || w_bit_end) ? '0 : r_baud + 1'b1;
            if (w_load) begin
                r_shift <= {1'b1, w_byte, 1'b0};
                r_bit   <= '0;
                if (r_state == SEND) r_frames <= r_frames + 1'b1;
                if (w_is_pix) begin
                    r_addr <= (r_addr == AW'(N - 1)) ? '0 : r_addr + 1'b1;
                    if (r_addr == AW'(N - 1)) r_plane <= 1'b1;
`ifdef GRAD_SYNC_HEADER_EN
                    if (r_addr == AW'(N - 1)) r_hdr <= '0;
                end else begin
                    r_hdr <= r_hdr + 1'b1;
`endif
                end
            end else if (w_bit_end && r_state == SEND) begin
                r_shift <= {1'b1, r_shift[9:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_grad_img_sender.sv
// tb_grad_img_sender: randomized and directed checks of grad_img_sender against a frame-level UART model.
module tb_grad_img_sender;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int CPB  = 4;
    localparam int N    = W * H;
    localparam int AW   = $clog2(N);
`ifdef GRAD_SYNC_HEADER_EN
    localparam int HDR  = 2;
`else
    localparam int HDR  = 0;
`endif
    localparam int FRAMES = 2 * (N + HDR);
    localparam int FLEN   = 10 * CPB;
    localparam int REC    = FRAMES * FLEN + 40;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] xa, ya;
    logic [7:0]    xp, yp, xd, yd;
    logic          tx, busy, done;
    logic [7:0]    xmem [N];
    logic [7:0]    ymem [N];
    logic          s_tx [REC];
    logic          s_busy [REC];
    logic          s_done [REC];
    int            s_xa [REC];
    int            s_ya [REC];
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        xd <= xmem[xa];
        xp <= xd;
        yd <= ymem[ya];
        yp <= yd;
    end

    grad_img_sender #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .CLOCKS_PER_BAUD(CPB)) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start),
        .x_read_addr(xa), .x_pixel_in(xp),
        .y_read_addr(ya), .y_pixel_in(yp),
        .tx(tx), .busy(busy), .done(done)
    );

    task automatic test_reset();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || xa !== '0 || ya !== '0) begin
            failures++;
            $display("FAIL reset_state tx=%b busy=%b done=%b xa=%0d ya=%0d required 1 0 0 0 0", tx, busy, done, xa, ya);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
        end
    endtask

    task automatic test_stream(input string name, input int extra);
        logic [7:0] exp[$];
        int         xs[$], ys[$];
        int         first, e, nbusy, ndone, idle_bad;
        exp = {};
        for (int p = 0; p < 2; p++) begin
            if (HDR != 0) begin
                exp.push_back(8'hA5);
                exp.push_back(8'h5A);
            end
            for (int i = 0; i < N; i++) exp.push_back(p == 0 ? xmem[i] : ymem[i]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < REC; i++) begin
            s_tx[i]   = tx;
            s_busy[i] = busy;
            s_done[i] = done;
            s_xa[i]   = int'(xa);
            s_ya[i]   = int'(ya);
            start     = (i == extra);
            @(negedge clk);
        end
        start = 1'b0;
        first = -1;
        for (int i = 0; i < REC && first < 0; i++) if (s_tx[i] === 1'b0) first = i;
        checks++;
        if (first < 0 || first > 4) begin
            failures++;
            $display("FAIL %s startup first_start=%0d required 0..4", name, first);
        end
        if (first < 0) first = 0;
        for (int f = 0; f < FRAMES; f++) begin
            logic [9:0] want;
            logic [7:0] got;
            logic       ok;
            want = {1'b1, exp[f], 1'b0};
            ok   = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if (k >= 1 && k <= 8) got[k-1] = s_tx[first + f*FLEN + k*CPB + CPB/2];
                for (int c = 0; c < CPB; c++) if (s_tx[first + f*FLEN + k*CPB + c] !== want[k]) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s frame%0d got=%h required=%h (start/stop/timing included)", name, f, got, exp[f]);
            end
        end
        e = first + FRAMES * FLEN;
        nbusy = 0;
        ndone = 0;
        idle_bad = 0;
        for (int i = 0; i < REC; i++) begin
            nbusy += int'(s_busy[i] === 1'b1);
            ndone += int'(s_done[i] === 1'b1);
            if (i >= e && s_tx[i] !== 1'b1) idle_bad++;
        end
        checks++;
        if (nbusy < FRAMES * FLEN || nbusy > FRAMES * FLEN + 4) begin
            failures++;
            $display("FAIL %s busy_len got=%0d required %0d..%0d", name, nbusy, FRAMES*FLEN, FRAMES*FLEN + 4);
        end
        checks++;
        if (ndone != 1 || s_done[e] !== 1'b1) begin
            failures++;
            $display("FAIL %s done got count=%0d at_end=%b required count=1 at_end=1", name, ndone, s_done[e]);
        end
        checks++;
        if (s_busy[e] !== 1'b0 || s_busy[e-1] !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_fall got=%b%b required 10", name, s_busy[e-1], s_busy[e]);
        end
        checks++;
        if (idle_bad != 0) begin
            failures++;
            $display("FAIL %s tx_idle_after got=%0d low samples required 0", name, idle_bad);
        end
        xs = {s_xa[0]};
        ys = {s_ya[0]};
        for (int i = 1; i < REC; i++) begin
            if (s_xa[i] != xs[$]) xs.push_back(s_xa[i]);
            if (s_ya[i] != ys[$]) ys.push_back(s_ya[i]);
        end
        for (int p = 0; p < 2; p++) begin
            int q[$];
            q = (p == 0) ? xs : ys;
            checks++;
            if (q.size() != N + 1 || q[N] != 0 || q[0] != 0) begin
                failures++;
                $display("FAIL %s addr_trace%0d got_len=%0d required_len=%0d", name, p, q.size(), N + 1);
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (q[i] != i) begin
                        failures++;
                        $display("FAIL %s addr_trace%0d step%0d got=%0d required=%0d", name, p, i, q[i], i);
                    end
                end
            end
        end
        checks++;
        if (s_xa[REC-1] != 0 || s_ya[REC-1] != 0) begin
            failures++;
            $display("FAIL %s idle_addr got=%0d/%0d required 0/0", name, s_xa[REC-1], s_ya[REC-1]);
        end
    endtask

    task automatic test_reset_mid();
        int ndone, nlow, nbusy;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3 + 10 * FLEN + 15; i++) begin
            ndone += int'(done === 1'b1);
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || (xa === '0 && ya === '0)) begin
            failures++;
            $display("FAIL reset_mid precondition busy=%b xa=%0d ya=%0d required busy=1 and a nonzero address", busy, xa, ya);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || xa !== '0 || ya !== '0) begin
            failures++;
            $display("FAIL reset_mid_immediate tx=%b busy=%b done=%b xa=%0d ya=%0d required 1 0 0 0 0", tx, busy, done, xa, ya);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nlow = 0;
        nbusy = 0;
        for (int i = 0; i < REC; i++) begin
            ndone += int'(done === 1'b1);
            nlow  += int'(tx !== 1'b1);
            nbusy += int'(busy !== 1'b0);
            @(negedge clk);
        end
        checks++;
        if (ndone != 0 || nlow != 0 || nbusy != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet done=%0d tx_low=%0d busy=%0d required 0 0 0", ndone, nlow, nbusy);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            xmem[i] = 8'(i + 1);
            ymem[i] = 8'(8'h80 + i);
        end
        test_reset();
        test_stream("basic", -1);
        test_stream("start_while_busy", 3 + 5 * FLEN + 10);
        test_reset_mid();
        test_stream("after_reset", -1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                xmem[i] = 8'($urandom);
                ymem[i] = 8'($urandom);
            end
            test_stream("random", int'($urandom_range(FRAMES * FLEN - 1, 0)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
